// File: rtl/threshold_frame_ctrl.sv
// Frame sequencer for the thresholding stage: streams one frame through
// the threshold block, stores the sparse output and supervises it.
module threshold_frame_ctrl #(
  parameter int N       = 2048,
  parameter int AW      = 11,
  parameter int DW      = 12,
  parameter int TIMEOUT = N + 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic [AW:0]   nnz_count,
  output logic [15:0]   frame_count,
  output logic          timeout_err,
  output logic          in_rd_en,
  output logic [AW-1:0] in_rd_addr,
  input  logic [DW-1:0] in_rd_data,
  output logic          th_reset,
  output logic          th_enable,
  output logic [DW-1:0] th_sig,
  input  logic [DW-1:0] th_y,
  input  logic          th_done,
  input  logic [AW:0]   th_id,
  output logic          out_wr_en,
  output logic [AW-1:0] out_wr_addr,
  output logic [DW-1:0] out_wr_data
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    RECOVER
  } state_t;

  localparam logic [AW-1:0] LAST_ID = AW'(N - 1);
  localparam logic [AW+1:0] WD_LAST = (AW+2)'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   acc_q, acc_d;
  logic [AW:0]   nnz_q, nnz_d;
  logic [15:0]   fc_q, fc_d;
  logic [AW+1:0] wd_q, wd_d;
  logic          rec_q, rec_d;
  logic          fd_q, fd_d;
  logic          to_q, to_d;

  logic          cap;
  logic          nz;
  logic          last;
  logic          accept;
  logic [AW:0]   acc_inc;
  logic          unused_id;

  assign unused_id = th_id[AW];

  // Start is refused during the frame_done cycle so the threshold
  // block always gets a full idle cycle between frames.
  assign accept  = (state_q == IDLE) && start && !fd_q && !reset;
  assign cap     = th_done && !reset;
  assign nz      = cap && (th_y != '0);
  assign last    = cap && (th_id[AW-1:0] == LAST_ID);
  assign acc_inc = acc_q + {{AW{1'b0}}, nz};

  assign th_sig      = in_rd_data;
  assign th_reset    = reset || (state_q == RECOVER);
  assign busy        = (state_q != IDLE) && !reset;
  assign out_wr_en   = cap;
  assign out_wr_addr = reset ? '0 : th_id[AW-1:0];
  assign out_wr_data = reset ? '0 : th_y;
  assign frame_done  = fd_q;
  assign nnz_count   = nnz_q;
  assign frame_count = fc_q;
  assign timeout_err = to_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      nnz_q   <= '0;
      fc_q    <= '0;
      wd_q    <= '0;
      rec_q   <= 1'b0;
      fd_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      nnz_q   <= nnz_d;
      fc_q    <= fc_d;
      wd_q    <= wd_d;
      rec_q   <= rec_d;
      fd_q    <= fd_d;
      to_q    <= to_d;
    end
  end

  // Next state, read-side strobes, watchdog and frame bookkeeping.
  // The watchdog holds the number of cycles elapsed since th_enable.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    acc_d      = acc_inc;
    nnz_d      = nnz_q;
    fc_d       = fc_q;
    wd_d       = wd_q;
    rec_d      = rec_q;
    fd_d       = 1'b0;
    to_d       = to_q;
    in_rd_en   = 1'b0;
    in_rd_addr = '0;
    th_enable  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          th_enable = 1'b1;
          in_rd_en  = 1'b1;
          addr_d    = AW'(1);
          acc_d     = '0;
          to_d      = 1'b0;
          wd_d      = (AW+2)'(1);
          state_d   = RUN;
        end
      end
      RUN: begin
        in_rd_en   = 1'b1;
        in_rd_addr = addr_q;
        addr_d     = addr_q + AW'(1);
        wd_d       = wd_q + (AW+2)'(1);
        if (addr_q == LAST_ID) state_d = DRAIN;
        if (wd_q == WD_LAST) begin
          to_d    = 1'b1;
          rec_d   = 1'b0;
          state_d = RECOVER;
        end
      end
      DRAIN: begin
        wd_d = wd_q + (AW+2)'(1);
        if (last) begin
          fd_d    = 1'b1;
          nnz_d   = acc_inc;
          fc_d    = fc_q + 16'd1;
          state_d = IDLE;
        end else if (wd_q == WD_LAST) begin
          to_d    = 1'b1;
          rec_d   = 1'b0;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        rec_d = 1'b1;
        if (rec_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      in_rd_en   = 1'b0;
      in_rd_addr = '0;
      th_enable  = 1'b0;
    end
  end

endmodule

// File: tb/tb_threshold_frame_ctrl.sv
// Testbench for threshold_frame_ctrl with RAM and threshold-block
// models and a frame-level reference of the expected sparse output.
module tb_threshold_frame_ctrl;
  localparam int N       = 2048;
  localparam int AW      = 11;
  localparam int DW      = 12;
  localparam int TIMEOUT = N + 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, frame_done, timeout_err;
  logic [AW:0]   nnz_count;
  logic [15:0]   frame_count;
  logic          in_rd_en;
  logic [AW-1:0] in_rd_addr;
  logic [DW-1:0] in_rd_data = '0;
  logic          th_reset, th_enable;
  logic [DW-1:0] th_sig;
  logic [DW-1:0] th_y = '0;
  logic          th_done = 1'b0;
  logic [AW:0]   th_id = '0;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic [DW-1:0] out_wr_data;

  threshold_frame_ctrl #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .frame_done(frame_done), .nnz_count(nnz_count),
    .frame_count(frame_count), .timeout_err(timeout_err),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .in_rd_data(in_rd_data), .th_reset(th_reset),
    .th_enable(th_enable), .th_sig(th_sig), .th_y(th_y),
    .th_done(th_done), .th_id(th_id), .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_fc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard threshold at 84 applied by the threshold block.
  function automatic logic [DW-1:0] thr(input logic [DW-1:0] x);
    int v;
    v = int'(signed'(x));
    if (v > 84 || v < -84) return x;
    return '0;
  endfunction

  // Input sample RAM, one cycle read latency.
  logic [DW-1:0] ram [N];
  always @(posedge clk) if (in_rd_en) in_rd_data <= ram[in_rd_addr];

  // Threshold block: enable -> WORKING for N cycles, output one later.
  logic wk = 1'b0;
  int   k = 0;
  bit   stall = 1'b0;
  always @(posedge clk) begin
    if (th_reset) begin
      wk <= 1'b0; k <= 0; th_done <= 1'b0; th_y <= '0; th_id <= '0;
    end else begin
      th_done <= wk && !(stall && k > 100);
      th_y    <= thr(th_sig);
      th_id   <= (AW+1)'(k);
      if (th_enable) begin
        wk <= 1'b1; k <= 0;
      end else if (wk) begin
        if (k == N - 1) wk <= 1'b0;
        k <= k + 1;
      end
    end
  end

  // Output RAM tagged with the frame generation that wrote each word.
  logic [DW-1:0] omem [N];
  int            wgen [N];
  int            gen = 0;
  always @(posedge clk)
    if (out_wr_en) begin
      omem[out_wr_addr] <= out_wr_data;
      wgen[out_wr_addr] <= gen;
    end

  // Event monitor.
  int fdq[$];
  int nnzq[$];
  int fcq[$];
  int wr_cnt = 0, rd_cnt = 0, en_cnt = 0, thr_cnt = 0;
  int to_cyc = -1;
  bit to_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) begin
        fdq.push_back(cyc);
        nnzq.push_back(int'(nnz_count));
        fcq.push_back(int'(frame_count));
      end
      if (out_wr_en) wr_cnt++;
      if (in_rd_en) rd_cnt++;
      if (th_enable) en_cnt++;
      if (th_reset) thr_cnt++;
      if (timeout_err && !to_prev) to_cyc = cyc;
      to_prev = timeout_err;
    end
  end

  function automatic int fdc(input int i);
    return (i < fdq.size()) ? fdq[i] : -1;
  endfunction
  function automatic int nnzc(input int i);
    return (i < nnzq.size()) ? nnzq[i] : -1;
  endfunction
  function automatic int fcc(input int i);
    return (i < fcq.size()) ? fcq[i] : -1;
  endfunction

  function automatic int exp_nnz();
    int n = 0;
    for (int i = 0; i < N; i++) if (thr(ram[i]) != '0) n++;
    return n;
  endfunction

  function automatic int bad_words(input int g);
    int n = 0;
    for (int i = 0; i < N; i++)
      if (wgen[i] != g || omem[i] !== thr(ram[i])) n++;
    return n;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      ram[i] = DW'($urandom_range(600) - 300);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #2;
    end
  endtask

  // One-cycle start; samples the start-cycle strobes for the caller.
  task automatic start_frame(output int s, output bit en_s,
                             output int addr_s);
    @(posedge clk); #2;
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    en_s = th_enable && in_rd_en;
    addr_s = int'(in_rd_addr);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (fdq.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, frame_done, timeout_err, in_rd_en, th_enable, out_wr_en}
        !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000000",
        {busy, frame_done, timeout_err, in_rd_en, th_enable, out_wr_en});
    end
    checks++;
    if (th_reset !== 1'b1) begin
      failures++;
      $display("FAIL reset_th_reset got=%b exp=1", th_reset);
    end
    checks++;
    if (nnz_count !== '0 || frame_count !== '0 || in_rd_addr !== '0 ||
        out_wr_addr !== '0 || out_wr_data !== '0) begin
      failures++;
      $display("FAIL reset_values nnz=%0d fc=%0d ra=%0d wa=%0d wd=%0d exp=0",
        nnz_count, frame_count, in_rd_addr, out_wr_addr, out_wr_data);
    end
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  // Runs one frame from the current RAM and checks it completely.
  task automatic run_frame(input string nm, input int want_nnz);
    int s, a, n0, w0, e;
    bit en, ok;
    gen++;
    n0 = fdq.size();
    w0 = wr_cnt;
    e = exp_nnz();
    start_frame(s, en, a);
    checks++;
    if (!en || a != 0) begin
      failures++;
      $display("FAIL %s_start_strobe got en=%0d addr=%0d exp en=1 addr=0",
        nm, en, a);
    end
    wait_frames(n0 + 1, N + 20, ok);
    exp_fc++;
    checks++;
    if (fdc(n0) != s + N + 2) begin
      failures++;
      $display("FAIL %s_done_cycle got=%0d exp=%0d", nm, fdc(n0), s + N + 2);
    end
    if (want_nnz >= 0) begin
      checks++;
      if (e != want_nnz) begin
        failures++;
        $display("FAIL %s_pattern_nnz got=%0d exp=%0d", nm, e, want_nnz);
      end
    end
    checks++;
    if (nnzc(n0) != e) begin
      failures++;
      $display("FAIL %s_nnz got=%0d exp=%0d", nm, nnzc(n0), e);
    end
    checks++;
    if (fcc(n0) != (exp_fc & 16'hFFFF)) begin
      failures++;
      $display("FAIL %s_frame_count got=%0d exp=%0d", nm, fcc(n0), exp_fc);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt - w0 != N || bad_words(gen) != 0) begin
      failures++;
      $display("FAIL %s_out_ram writes=%0d bad=%0d exp writes=%0d bad=0",
        nm, wr_cnt - w0, bad_words(gen), N);
    end
    checks++;
    if (fdq.size() - n0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_single_done pulses=%0d busy=%b exp 1 0",
        nm, fdq.size() - n0, busy);
    end
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < N; i++) ram[i] = (i % 16 == 0) ? DW'(200) : '0;
    run_frame("single", 128);
  endtask

  task automatic test_random_frame();
    fill_random();
    run_frame("random", -1);
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < N; i++) ram[i] = '0;
    run_frame("zero", 0);
  endtask

  task automatic test_back_to_back();
    int s, a, n0, r0, e0, e;
    bit en, ok;
    fill_random();
    gen++;
    e = exp_nnz();
    n0 = fdq.size();
    r0 = rd_cnt;
    e0 = en_cnt;
    start_frame(s, en, a);
    wait_until(s + N + 2);
    start = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    start = 1'b0;
    wait_frames(n0 + 2, N + 20, ok);
    exp_fc += 2;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (fdq.size() - n0 != 2 || en_cnt - e0 != 2 || rd_cnt - r0 != 2 * N)
    begin
      failures++;
      $display("FAIL b2b_counts frames=%0d en=%0d rd=%0d exp 2 2 %0d",
        fdq.size() - n0, en_cnt - e0, rd_cnt - r0, 2 * N);
    end
    checks++;
    if (fdc(n0 + 1) != s + 2 * N + 5) begin
      failures++;
      $display("FAIL b2b_second_done got=%0d exp=%0d",
        fdc(n0 + 1), s + 2 * N + 5);
    end
    checks++;
    if (nnzc(n0) != e || nnzc(n0 + 1) != e ||
        frame_count !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL b2b_nnz got=%0d,%0d fc=%0d exp=%0d fc=%0d",
        nnzc(n0), nnzc(n0 + 1), frame_count, e, exp_fc);
    end
    checks++;
    if (bad_words(gen) != 0) begin
      failures++;
      $display("FAIL b2b_out_ram bad=%0d exp=0", bad_words(gen));
    end
  endtask

  task automatic test_watchdog();
    int s, a, n0, t0;
    bit en, hit;
    fill_random();
    stall = 1'b1;
    n0 = fdq.size();
    t0 = thr_cnt;
    to_cyc = -1;
    start_frame(s, en, a);
    hit = 1'b0;
    for (int i = 0; i < TIMEOUT + 20 && !hit; i++) begin
      @(posedge clk); #1;
      hit = timeout_err;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (to_cyc != s + TIMEOUT) begin
      failures++;
      $display("FAIL wd_timeout_cycle got=%0d exp=%0d", to_cyc, s + TIMEOUT);
    end
    checks++;
    if (thr_cnt - t0 != 2) begin
      failures++;
      $display("FAIL wd_th_reset_len got=%0d exp=2", thr_cnt - t0);
    end
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || fdq.size() != n0 ||
        frame_count !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL wd_after busy=%b err=%b dones=%0d fc=%0d exp 0 1 0 %0d",
        busy, timeout_err, fdq.size() - n0, frame_count, exp_fc);
    end
    stall = 1'b0;
    start_frame(s, en, a);
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL wd_err_clear got=%b exp=0", timeout_err);
    end
    wait_frames(n0 + 1, N + 20, hit);
    exp_fc++;
    checks++;
    if (fdc(n0) != s + N + 2 || nnzc(n0) != exp_nnz()) begin
      failures++;
      $display("FAIL wd_next_frame done=%0d nnz=%0d exp %0d %0d",
        fdc(n0), nnzc(n0), s + N + 2, exp_nnz());
    end
  endtask

  task automatic test_reset_mid();
    int s, a, n0, w0;
    bit en, ok;
    fill_random();
    n0 = fdq.size();
    start_frame(s, en, a);
    wait_until(s + 500);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (th_reset !== 1'b1 || busy !== 1'b0 || out_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_during th_reset=%b busy=%b wr=%b exp 1 0 0",
        th_reset, busy, out_wr_en);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    exp_fc = 0;
    w0 = wr_cnt;
    repeat (N + 10) @(posedge clk);
    #1;
    checks++;
    if (fdq.size() != n0 || wr_cnt != w0 || busy !== 1'b0 ||
        frame_count !== 16'd0 || nnz_count !== '0) begin
      failures++;
      $display("FAIL rst_mid_after dones=%0d wr=%0d busy=%b fc=%0d nnz=%0d exp 0",
        fdq.size() - n0, wr_cnt - w0, busy, frame_count, nnz_count);
    end
    run_frame("post_rst", -1);
  endtask

  task automatic test_start_held();
    int s, n0, e0, e;
    bit ok;
    fill_random();
    gen++;
    e = exp_nnz();
    n0 = fdq.size();
    e0 = en_cnt;
    @(posedge clk); #2;
    s = cyc;
    start = 1'b1;
    repeat (3 * N) @(posedge clk);
    #2;
    start = 1'b0;
    checks++;
    if (fdq.size() - n0 != 2) begin
      failures++;
      $display("FAIL held_two_done got=%0d exp=2", fdq.size() - n0);
    end
    wait_frames(n0 + 3, N + 40, ok);
    exp_fc += 3;
    repeat (N + 10) @(posedge clk);
    #1;
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (fdc(n0 + f) != s + f * (N + 3) + N + 2 || nnzc(n0 + f) != e) begin
        failures++;
        $display("FAIL held_frame%0d done=%0d nnz=%0d exp %0d %0d", f,
          fdc(n0 + f), nnzc(n0 + f), s + f * (N + 3) + N + 2, e);
      end
    end
    checks++;
    if (en_cnt - e0 != 3 || frame_count !== 16'(exp_fc) ||
        bad_words(gen) != 0) begin
      failures++;
      $display("FAIL held_totals en=%0d fc=%0d bad=%0d exp 3 %0d 0",
        en_cnt - e0, frame_count, bad_words(gen), exp_fc);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      omem[i] = '0;
      wgen[i] = -1;
      ram[i] = '0;
    end
    test_reset();
    test_single_frame();
    test_random_frame();
    test_all_zero();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    test_start_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
